// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86 instruction codes for the PC-update / RAS slice.
// Rev 1.0
`default_nettype none

package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] I_MAX    = 4'hB;

endpackage

`default_nettype wire

// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack with saturating occupancy count.
// Rev 1.0
`default_nettype none

module ras_stack #(
  parameter int ADDR_W    = 64,
  parameter int RAS_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic                           pop,
  input  logic [ADDR_W-1:0]              push_data,
  output logic [ADDR_W-1:0]              top_data,
  output logic [$clog2(RAS_DEPTH):0]     count
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] r_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  r_top;
  logic [CNT_W-1:0]  r_count;
  logic [PTR_W-1:0]  w_top_inc;
  logic [PTR_W-1:0]  w_top_dec;

  // Power-of-two depth lets the pointer wrap by plain truncation.
  assign w_top_inc = PTR_W'(r_top + 1'b1);
  assign w_top_dec = PTR_W'(r_top - 1'b1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_top   <= '0;
      r_count <= '0;
    end else if (push) begin
      r_top <= w_top_inc;
      if (r_count != FULL) r_count <= r_count + 1'b1;
    end else if (pop && (r_count != '0)) begin
      r_top   <= w_top_dec;
      r_count <= r_count - 1'b1;
    end
  end

  // Entries need no reset: top_data is masked while the stack is empty.
  always_ff @(posedge clk) begin
    if (!reset && push) r_mem[w_top_inc] <= push_data;
  end

  assign top_data = (r_count == '0) ? '0 : r_mem[r_top];
  assign count    = r_count;

endmodule

`default_nettype wire

// File: rtl/pc_update_ras.sv
// pc_update_ras: registered next-PC select with return-address prediction,
// stall hold, sticky halt and invalid-icode flags. Rev 1.0
`default_nettype none

module pc_update_ras
  import y86_pkg::*;
#(
  parameter int              ADDR_W    = 64,
  parameter int              RAS_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [3:0]        icode,
  input  logic              cnd,
  input  logic [ADDR_W-1:0] valc,
  input  logic [ADDR_W-1:0] valM,
  input  logic [ADDR_W-1:0] valP,
  output logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] ras_top,
  output logic              ras_valid,
  output logic              ras_mispredict,
  output logic              halted,
  output logic              bad_icode
);

  localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

  logic [ADDR_W-1:0] r_pc;
  logic              r_mispredict;
  logic              r_halted;
  logic              r_bad_icode;
  logic              w_hold;
  logic              w_push;
  logic              w_pop;
  logic [CNT_W-1:0]  w_count;

  assign w_hold = stall | r_halted | r_bad_icode;
  assign w_push = !w_hold && (icode == I_CALL);
  assign w_pop  = !w_hold && (icode == I_RET) && ras_valid;

  ras_stack #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (valP),
    .top_data  (ras_top),
    .count     (w_count)
  );

  assign ras_valid = (w_count != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc         <= RESET_PC;
      r_mispredict <= 1'b0;
      r_halted     <= 1'b0;
      r_bad_icode  <= 1'b0;
    end else if (w_hold) begin
      r_mispredict <= 1'b0;
    end else begin
      // A ret into an empty stack has no prediction and counts as a miss.
      r_mispredict <= (icode == I_RET) && (!ras_valid || (ras_top != valM));
      if (icode > I_MAX) begin
        r_bad_icode <= 1'b1;
      end else begin
        case (icode)
          I_HALT:  r_halted <= 1'b1;
          I_CALL:  r_pc     <= valc;
          I_RET:   r_pc     <= valM;
          I_JXX:   r_pc     <= cnd ? valc : valP;
          default: r_pc     <= valP;
        endcase
      end
    end
  end

  assign PC             = r_pc;
  assign ras_mispredict = r_mispredict;
  assign halted         = r_halted;
  assign bad_icode      = r_bad_icode;

endmodule

`default_nettype wire

// File: doc/pc_update_ras.md
Name: pc_update_ras

Overview:
- Registered, parametrised successor to the sequential PC-update stage of the Y86 processor.
- Selects and latches the next PC from icode, cnd, valC, valM and valP.
- Adds a return-address stack (RAS) that predicts ret targets and flags mispredictions.
- Adds stall hold, halt latching and invalid-icode detection; sits between the write-back stage and fetch.

Parameters:
ADDR_W, 64, width of PC and all address inputs
RAS_DEPTH, 8, number of RAS entries; power of two, minimum 2
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
stall  in  1  1 = hold all state this cycle
icode  in  4  instruction code of the retiring instruction
cnd  in  1  condition result for jXX
valc  in  ADDR_W  constant/destination field
valM  in  ADDR_W  value read from memory (ret target)
valP  in  ADDR_W  fall-through address
PC  out  ADDR_W  registered program counter
ras_top  out  ADDR_W  current RAS top entry (predicted return address)
ras_valid  out  1  1 when RAS count > 0
ras_mispredict  out  1  one-cycle pulse after a ret whose valM differs from the prediction
halted  out  1  sticky; set by halt (icode 0)
bad_icode  out  1  sticky; set by icode > 4'hB

Behaviour:
- Reset, taking priority over stall:
  - PC = RESET_PC; halted = 0; bad_icode = 0; ras_mispredict = 0; RAS count = 0; top pointer = 0.
  - ras_valid = 0; ras_top = 0 while the RAS is empty.
- Hold conditions: when stall = 1, or halted = 1, or bad_icode = 1, all registers hold and ras_mispredict = 0.
- Next PC, applied on the clock edge (one-cycle latency; PC is visible the cycle after the inputs):
  - icode 8 (call): PC = valc.
  - icode 9 (ret): PC = valM; valM is authoritative and the RAS prediction never overrides it.
  - icode 7 (jXX): PC = cnd ? valc : valP.
  - icode 0 (halt): PC holds; halted set.
  - icode > 4'hB: PC holds; bad_icode set.
  - Any other icode: PC = valP.
- RAS push, on call: write valP at top+1, then top = top+1 (mod RAS_DEPTH); count = min(count+1, RAS_DEPTH).
- RAS overflow: on push when count = RAS_DEPTH, the oldest entry is overwritten circularly and count stays at RAS_DEPTH. No error is raised.
- RAS pop, on ret with count > 0:
  - Compare the entry at top with valM.
  - top = top-1 (mod RAS_DEPTH); count = count-1.
  - ras_mispredict = 1 for the next cycle if the two differ.
- Ret with empty RAS: no pop; count stays 0; ras_mispredict = 1 for the next cycle.
- call and ret are mutually exclusive by icode, so push and pop are never simultaneous.
- ras_top is combinational from the stack array at top; it equals 0 when count = 0.
- All address arithmetic is modulo 2^ADDR_W with no carry-out; pointer arithmetic is modulo RAS_DEPTH.
- Reset asserted mid-operation, including while stalled or halted, clears everything in the same edge.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants: I_HALT=0, I_NOP=1, I_RRMOVQ=2, I_IRMOVQ=3, I_RMMOVQ=4, I_MRMOVQ=5, I_OPQ=6, I_JXX=7, I_CALL=8, I_RET=9, I_PUSHQ=A, I_POPQ=B.
  - Localparam I_MAX = 4'hB.
- Sub-module ras_stack (parameters ADDR_W, RAS_DEPTH):
  - Inputs: clk, reset, push, pop, push_data.
  - Outputs: top_data, count.
  - Implements the circular pointer and saturating count.
- pc_update_ras contains the next-PC mux, hold logic, sticky flags and the mispredict compare.

Test Plan:
1. Reset with RESET_PC = 0x100, then icode 1, valP = 0x102 for one cycle -> after reset PC = 0x100, all flags 0; next edge PC = 0x102.
2. icode 7, valc = 0x200, valP = 0x109, cnd = 0 then cnd = 1 -> PC = 0x109, then PC = 0x200; RAS unchanged.
3. call with valc = 0x400, valP = 0x10A, then ret with valM = 0x10A -> after call PC = 0x400, ras_top = 0x10A, ras_valid = 1; after ret PC = 0x10A, ras_valid = 0, ras_mispredict = 0.
4. RAS_DEPTH = 8; nine calls with valP = 0x10..0x18, then nine rets with matching valM -> first eight rets have no mispredict; ninth ret sees an empty RAS, pulses ras_mispredict = 1, and PC = valM.
5. ret with valM = 0x500 while ras_top = 0x10A -> PC = 0x500; ras_mispredict high for exactly one cycle.
6. The following must all hold:
   - stall = 1 with icode 8 -> PC and RAS unchanged.
   - icode 0 -> halted = 1, and PC frozen for 3 further cycles of icode 1.
   - icode 4'hE -> bad_icode = 1.
   - reset -> all flags clear and PC = RESET_PC.
